// File: rtl/bam_acc_pkg.sv
// Shared types and default widths for the approximate-multiplier product accumulator.
package bam_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    localparam int DEF_PROD_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 24;

    // Count must hold the value MAX_TERMS itself, hence the +1.
    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/bam_product_accumulator_if.sv
// Input product stream and output result handshake of the product accumulator.
interface bam_product_accumulator_if #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 9
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PROD_WIDTH-1:0] in_product;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_sum;
    logic [CNT_WIDTH-1:0]  out_count;
    logic                  out_overflow;
    logic                  out_forced;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow, out_forced
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow, out_forced
    );
endinterface

// File: rtl/bam_sat_add.sv
// Accumulator adder: ACC_WIDTH sum plus zero-extended product, clamping or wrapping on carry.
module bam_sat_add #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter bit SATURATE   = 1'b1
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [PROD_WIDTH-1:0] prod_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  carry_o
);
    logic [ACC_WIDTH:0] sum_ext_s;

    assign sum_ext_s = {1'b0, acc_i} + {{(ACC_WIDTH - PROD_WIDTH + 1){1'b0}}, prod_i};
    assign carry_o   = sum_ext_s[ACC_WIDTH];
    // An all-ones accumulator carries on any nonzero add, so a clamp persists for the burst.
    assign sum_o     = (SATURATE && carry_o) ? {ACC_WIDTH{1'b1}} : sum_ext_s[ACC_WIDTH-1:0];
endmodule

// File: rtl/bam_product_accumulator.sv
// Streaming MAC back end: sums bursts of multiplier products and presents sum, count and flags.
module bam_product_accumulator
    import bam_acc_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int MAX_TERMS  = 256,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    bam_product_accumulator_if.slave bus
);
    localparam int CNT_WIDTH = cnt_width(MAX_TERMS);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TERMS);

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_forced_q, out_forced_d;

    logic [ACC_WIDTH-1:0] add_sum_s;
    logic                 add_carry_s;
    logic                 accept_s;
    logic [CNT_WIDTH-1:0] count_inc_s;
    logic                 hit_max_s;

    bam_sat_add #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
    ) u_add (
        .acc_i   (acc_q),
        .prod_i  (bus.in_product),
        .sum_o   (add_sum_s),
        .carry_o (add_carry_s)
    );

    assign accept_s    = bus.in_valid & in_ready_q;
    assign count_inc_s = count_q + CNT_WIDTH'(1);
    assign hit_max_s   = (count_inc_s == MAX_CNT);

    // Next-state decode for the burst FSM, accumulator and result registers.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_count_d  = out_count_q;
        out_ovf_d    = out_ovf_q;
        out_forced_d = out_forced_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    acc_d   = add_sum_s;
                    count_d = count_inc_s;
                    ovf_d   = ovf_q | add_carry_s;
                    if (bus.in_last || hit_max_s) begin
                        state_d      = HOLD;
                        out_valid_d  = 1'b1;
                        out_sum_d    = add_sum_s;
                        out_count_d  = count_inc_s;
                        out_ovf_d    = ovf_q | add_carry_s;
                        out_forced_d = hit_max_s & ~bus.in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d      = IDLE;
                    acc_d        = {ACC_WIDTH{1'b0}};
                    count_d      = {CNT_WIDTH{1'b0}};
                    ovf_d        = 1'b0;
                    out_valid_d  = 1'b0;
                    out_sum_d    = {ACC_WIDTH{1'b0}};
                    out_count_d  = {CNT_WIDTH{1'b0}};
                    out_ovf_d    = 1'b0;
                    out_forced_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d != HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= {ACC_WIDTH{1'b0}};
            count_q      <= {CNT_WIDTH{1'b0}};
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sum_q    <= {ACC_WIDTH{1'b0}};
            out_count_q  <= {CNT_WIDTH{1'b0}};
            out_ovf_q    <= 1'b0;
            out_forced_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_count_q  <= out_count_d;
            out_ovf_q    <= out_ovf_d;
            out_forced_q <= out_forced_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_forced   = out_forced_q;
endmodule

// File: tb/tb_bam_product_accumulator.sv
// Directed bench: default config, a 17-bit saturating/MAX_TERMS=4 config and a 17-bit wrapping config.
module tb_bam_product_accumulator;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bam_product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(9)) bif_a ();
    bam_product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(3)) bif_b ();
    bam_product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(9)) bif_c ();

    bam_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .MAX_TERMS(256), .SATURATE(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bif_a));
    bam_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(17), .MAX_TERMS(4), .SATURATE(1'b1))
        dut_b (.clk(clk), .rst(rst), .bus(bif_b));
    bam_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(17), .MAX_TERMS(256), .SATURATE(1'b0))
        dut_c (.clk(clk), .rst(rst), .bus(bif_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [15:0] p, input logic l);
        bif_a.in_valid = v; bif_a.in_product = p; bif_a.in_last = l;
    endtask

    task automatic drive_bc(input logic v, input logic [15:0] p, input logic l);
        bif_b.in_valid = v; bif_b.in_product = p; bif_b.in_last = l;
        bif_c.in_valid = v; bif_c.in_product = p; bif_c.in_last = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bif_a.out_valid !== 1'b0 || bif_a.out_sum !== 24'h0 || bif_a.out_count !== 9'd0 ||
            bif_a.out_overflow !== 1'b0 || bif_a.out_forced !== 1'b0 || bif_a.in_ready !== 1'b1) begin
            $display("FAIL reset_a: got v=%b sum=%h cnt=%0d ovf=%b frc=%b rdy=%b, want v=0 sum=0 cnt=0 ovf=0 frc=0 rdy=1",
                     bif_a.out_valid, bif_a.out_sum, bif_a.out_count, bif_a.out_overflow, bif_a.out_forced, bif_a.in_ready);
            errors++;
        end
        checks++;
        if (bif_b.out_valid !== 1'b0 || bif_b.out_sum !== 17'h0 || bif_b.in_ready !== 1'b1 ||
            bif_c.out_valid !== 1'b0 || bif_c.out_sum !== 17'h0 || bif_c.in_ready !== 1'b1) begin
            $display("FAIL reset_bc: got b v=%b sum=%h rdy=%b c v=%b sum=%h rdy=%b, want v=0 sum=0 rdy=1",
                     bif_b.out_valid, bif_b.out_sum, bif_b.in_ready, bif_c.out_valid, bif_c.out_sum, bif_c.in_ready);
            errors++;
        end
    endtask

    task automatic test_basic();
        bif_a.out_ready = 1'b1;
        drive_a(1'b1, 16'h0010, 1'b0); tick();
        drive_a(1'b1, 16'h0020, 1'b0); tick();
        drive_a(1'b1, 16'h0030, 1'b1); tick();
        drive_a(1'b0, 16'h0000, 1'b0);
        checks++;
        if (bif_a.out_valid !== 1'b1 || bif_a.out_sum !== 24'h000060 || bif_a.out_count !== 9'd3 ||
            bif_a.out_overflow !== 1'b0 || bif_a.out_forced !== 1'b0 || bif_a.in_ready !== 1'b0) begin
            $display("FAIL basic_result: got v=%b sum=%h cnt=%0d ovf=%b frc=%b rdy=%b, want v=1 sum=000060 cnt=3 ovf=0 frc=0 rdy=0",
                     bif_a.out_valid, bif_a.out_sum, bif_a.out_count, bif_a.out_overflow, bif_a.out_forced, bif_a.in_ready);
            errors++;
        end
        tick();
        checks++;
        if (bif_a.out_valid !== 1'b0 || bif_a.in_ready !== 1'b1 || bif_a.out_sum !== 24'h0 || bif_a.out_count !== 9'd0) begin
            $display("FAIL basic_release: got v=%b rdy=%b sum=%h cnt=%0d, want v=0 rdy=1 sum=0 cnt=0",
                     bif_a.out_valid, bif_a.in_ready, bif_a.out_sum, bif_a.out_count);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        bif_a.out_ready = 1'b0;
        drive_a(1'b1, 16'hFFFF, 1'b1); tick();
        drive_a(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif_a.out_valid !== 1'b1 || bif_a.out_sum !== 24'h00FFFF || bif_a.out_count !== 9'd1 ||
                bif_a.in_ready !== 1'b0) begin
                $display("FAIL backpressure_hold[%0d]: got v=%b sum=%h cnt=%0d rdy=%b, want v=1 sum=00ffff cnt=1 rdy=0",
                         i, bif_a.out_valid, bif_a.out_sum, bif_a.out_count, bif_a.in_ready);
                errors++;
            end
            tick();
        end
        bif_a.out_ready = 1'b1;
        tick();
        checks++;
        if (bif_a.out_valid !== 1'b0 || bif_a.in_ready !== 1'b1) begin
            $display("FAIL backpressure_release: got v=%b rdy=%b, want v=0 rdy=1", bif_a.out_valid, bif_a.in_ready);
            errors++;
        end
    endtask

    task automatic test_saturation();
        bif_b.out_ready = 1'b1;
        bif_c.out_ready = 1'b1;
        drive_bc(1'b1, 16'hFFFF, 1'b0); tick();
        drive_bc(1'b1, 16'hFFFF, 1'b0); tick();
        drive_bc(1'b1, 16'hFFFF, 1'b1); tick();
        drive_bc(1'b0, 16'h0000, 1'b0);
        checks++;
        if (bif_b.out_valid !== 1'b1 || bif_b.out_sum !== 17'h1FFFF || bif_b.out_overflow !== 1'b1 ||
            bif_b.out_count !== 3'd3 || bif_b.out_forced !== 1'b0) begin
            $display("FAIL saturate_clamp: got v=%b sum=%h ovf=%b cnt=%0d frc=%b, want v=1 sum=1ffff ovf=1 cnt=3 frc=0",
                     bif_b.out_valid, bif_b.out_sum, bif_b.out_overflow, bif_b.out_count, bif_b.out_forced);
            errors++;
        end
        checks++;
        if (bif_c.out_valid !== 1'b1 || bif_c.out_sum !== 17'h0FFFD || bif_c.out_overflow !== 1'b1 ||
            bif_c.out_count !== 9'd3) begin
            $display("FAIL saturate_wrap: got v=%b sum=%h ovf=%b cnt=%0d, want v=1 sum=0fffd ovf=1 cnt=3",
                     bif_c.out_valid, bif_c.out_sum, bif_c.out_overflow, bif_c.out_count);
            errors++;
        end
        tick();
        checks++;
        if (bif_b.out_valid !== 1'b0 || bif_c.out_valid !== 1'b0 || bif_b.out_overflow !== 1'b0 ||
            bif_c.out_overflow !== 1'b0) begin
            $display("FAIL saturate_release: got b v=%b ovf=%b c v=%b ovf=%b, want all 0",
                     bif_b.out_valid, bif_b.out_overflow, bif_c.out_valid, bif_c.out_overflow);
            errors++;
        end
    endtask

    task automatic test_forced();
        bif_b.out_ready = 1'b0;
        bif_b.in_valid = 1'b1; bif_b.in_product = 16'h0001; bif_b.in_last = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bif_b.out_valid !== 1'b1 || bif_b.out_sum !== 17'd4 || bif_b.out_count !== 3'd4 ||
            bif_b.out_forced !== 1'b1 || bif_b.out_overflow !== 1'b0 || bif_b.in_ready !== 1'b0) begin
            $display("FAIL forced_result: got v=%b sum=%h cnt=%0d frc=%b ovf=%b rdy=%b, want v=1 sum=4 cnt=4 frc=1 ovf=0 rdy=0",
                     bif_b.out_valid, bif_b.out_sum, bif_b.out_count, bif_b.out_forced, bif_b.out_overflow, bif_b.in_ready);
            errors++;
        end
        tick();
        checks++;
        if (bif_b.out_valid !== 1'b1 || bif_b.out_count !== 3'd4 || bif_b.out_sum !== 17'd4) begin
            $display("FAIL forced_stall: got v=%b sum=%h cnt=%0d, want v=1 sum=4 cnt=4",
                     bif_b.out_valid, bif_b.out_sum, bif_b.out_count);
            errors++;
        end
        bif_b.out_ready = 1'b1;
        tick();
        checks++;
        if (bif_b.out_valid !== 1'b0 || bif_b.in_ready !== 1'b1 || dut_b.count_q !== 3'd0) begin
            $display("FAIL forced_handshake: got v=%b rdy=%b cnt_q=%0d, want v=0 rdy=1 cnt_q=0",
                     bif_b.out_valid, bif_b.in_ready, dut_b.count_q);
            errors++;
        end
        tick();
        bif_b.in_valid = 1'b0;
        checks++;
        if (dut_b.count_q !== 3'd1 || bif_b.out_valid !== 1'b0 || bif_b.in_ready !== 1'b1) begin
            $display("FAIL forced_new_burst: got cnt_q=%0d v=%b rdy=%b, want cnt_q=1 v=0 rdy=1",
                     dut_b.count_q, bif_b.out_valid, bif_b.in_ready);
            errors++;
        end
        bif_b.in_valid = 1'b1; bif_b.in_product = 16'h0000; bif_b.in_last = 1'b1;
        tick();
        bif_b.in_valid = 1'b0; bif_b.in_last = 1'b0;
        checks++;
        if (bif_b.out_valid !== 1'b1 || bif_b.out_sum !== 17'd1 || bif_b.out_count !== 3'd2 || bif_b.out_forced !== 1'b0) begin
            $display("FAIL forced_close: got v=%b sum=%h cnt=%0d frc=%b, want v=1 sum=1 cnt=2 frc=0",
                     bif_b.out_valid, bif_b.out_sum, bif_b.out_count, bif_b.out_forced);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        bif_a.out_ready = 1'b1;
        drive_a(1'b1, 16'h0100, 1'b0); tick();
        drive_a(1'b1, 16'h0100, 1'b0); tick();
        drive_a(1'b0, 16'h0000, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (bif_a.out_valid !== 1'b0 || bif_a.in_ready !== 1'b1 || bif_a.out_sum !== 24'h0) begin
            $display("FAIL reset_mid_abort: got v=%b rdy=%b sum=%h, want v=0 rdy=1 sum=0",
                     bif_a.out_valid, bif_a.in_ready, bif_a.out_sum);
            errors++;
        end
        drive_a(1'b1, 16'h0005, 1'b1); tick();
        drive_a(1'b0, 16'h0000, 1'b0);
        checks++;
        if (bif_a.out_valid !== 1'b1 || bif_a.out_sum !== 24'h000005 || bif_a.out_count !== 9'd1) begin
            $display("FAIL reset_mid_next: got v=%b sum=%h cnt=%0d, want v=1 sum=000005 cnt=1",
                     bif_a.out_valid, bif_a.out_sum, bif_a.out_count);
            errors++;
        end
        tick();
    endtask

    task automatic test_gaps_and_back_to_back();
        logic [15:0] vals [6];
        vals = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
        bif_a.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) drive_a(1'b1, vals[i/2], (i == 10));
            else            drive_a(1'b0, 16'h0000, 1'b0);
            tick();
        end
        checks++;
        if (bif_a.out_valid !== 1'b1 || bif_a.out_sum !== 24'h001515 || bif_a.out_count !== 9'd6) begin
            $display("FAIL gaps_result: got v=%b sum=%h cnt=%0d, want v=1 sum=001515 cnt=6",
                     bif_a.out_valid, bif_a.out_sum, bif_a.out_count);
            errors++;
        end
        bif_a.out_ready = 1'b1;
        drive_a(1'b1, 16'h0007, 1'b1);
        tick();
        bif_a.out_ready = 1'b0;
        checks++;
        if (bif_a.out_valid !== 1'b0 || bif_a.in_ready !== 1'b1 || bif_a.out_sum !== 24'h0) begin
            $display("FAIL b2b_no_bypass: got v=%b rdy=%b sum=%h, want v=0 rdy=1 sum=0",
                     bif_a.out_valid, bif_a.in_ready, bif_a.out_sum);
            errors++;
        end
        tick();
        drive_a(1'b0, 16'h0000, 1'b0);
        checks++;
        if (bif_a.out_valid !== 1'b1 || bif_a.out_sum !== 24'h000007 || bif_a.out_count !== 9'd1) begin
            $display("FAIL b2b_taken_late: got v=%b sum=%h cnt=%0d, want v=1 sum=000007 cnt=1",
                     bif_a.out_valid, bif_a.out_sum, bif_a.out_count);
            errors++;
        end
        bif_a.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive_a(1'b0, 16'h0000, 1'b0);
        drive_bc(1'b0, 16'h0000, 1'b0);
        bif_a.out_ready = 1'b0;
        bif_b.out_ready = 1'b0;
        bif_c.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_forced();
        test_reset_mid_burst();
        test_gaps_and_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
